// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the RV M-extension multiply/divide unit:
// funct3 op codes, FSM state encoding and the op-class decode helper.
`timescale 1ns/1ps
package rv_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    typedef struct packed {
        logic is_div;
        logic signed_a;
        logic signed_b;
        logic want_high;
    } mdu_class_t;

    function automatic mdu_class_t op_class(input logic [2:0] op);
        mdu_class_t c;
        c.is_div    = op[2];
        c.signed_a  = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
        c.signed_b  = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
        c.want_high = ~op[2] && (op != MDU_MUL);
        return c;
    endfunction

endpackage

// File: rtl/rv_mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
`timescale 1ns/1ps
module rv_mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_in < divisor always holds, so a non-negative difference fits in XLEN bits
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Multi-cycle RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Optional macro RV_MDU_FAST_MUL_EN: single-cycle multiply, iterative divide.
//   state  | meaning
//   S_IDLE | ready for a request
//   S_CALC | iterating XLEN shift-add / restoring-divide steps
//   S_DONE | result presented, waiting for i_out_ready
`timescale 1ns/1ps
module rv_muldiv_unit
    import rv_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_op,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   result_q;

    mdu_class_t        cls_in;
    logic              sa, sb, neg_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              div_zero, overflow, special;
    logic [XLEN-1:0]   special_res;
    logic              accept, direct_done;
    logic [XLEN-1:0]   direct_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, calc_nxt;
    logic [XLEN-1:0]   div_rem;
    logic              div_q;

    // Apply the latched sign and pick the architectural slice of the raw result
    function automatic logic [XLEN-1:0] fix_up(input logic [2:0] op, input logic neg,
                                               input logic [2*XLEN-1:0] raw);
        mdu_class_t        c;
        logic [XLEN-1:0]   part;
        logic [2*XLEN-1:0] prod;
        c = op_class(op);
        if (c.is_div) begin
            part = op[1] ? raw[2*XLEN-1:XLEN] : raw[XLEN-1:0];
            return neg ? -part : part;
        end
        prod = neg ? -raw : raw;
        return c.want_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    endfunction

    always_comb begin
        cls_in   = op_class(i_op);
        sa       = cls_in.signed_a & i_a[XLEN-1];
        sb       = cls_in.signed_b & i_b[XLEN-1];
        mag_a_in = sa ? -i_a : i_a;
        mag_b_in = sb ? -i_b : i_b;
        neg_in   = (cls_in.is_div & i_op[1]) ? sa : (sa ^ sb);
        div_zero = cls_in.is_div & (i_b == '0);
        overflow = cls_in.signed_a & cls_in.is_div & (i_a == INT_MIN) & (i_b == '1);
        special  = div_zero | overflow;
        if (div_zero) special_res = i_op[1] ? i_a : '1;
        else          special_res = i_op[1] ? '0 : i_a;
    end

`ifdef RV_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod   = (2*XLEN)'(mag_a_in) * (2*XLEN)'(mag_b_in);
    assign direct_done = special | ~cls_in.is_div;
    assign direct_res  = special ? special_res : fix_up(i_op, neg_in, fast_prod);
`else
    assign direct_done = special;
    assign direct_res  = special_res;
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    rv_mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in       (acc_q[2*XLEN-1:XLEN]),
        .dividend_bit (acc_q[XLEN-1]),
        .divisor      (opnd_q),
        .rem_out      (div_rem),
        .q_bit        (div_q)
    );

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        div_nxt  = {div_rem, acc_q[XLEN-2:0], div_q};
        calc_nxt = op_q[2] ? div_nxt : mul_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        o_in_ready  = (state_q == S_IDLE);
        o_busy      = (state_q != S_IDLE);
        o_out_valid = (state_q == S_DONE);
        accept      = i_in_valid & o_in_ready & ~i_flush;
        state_d     = state_q;
        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = direct_done ? S_DONE : S_CALC;
                S_CALC:  if (cnt_q == CNT_LAST) state_d = S_DONE;
                S_DONE:  if (i_out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
        end else if (i_flush) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= i_op;
            tag_q  <= i_tag;
            neg_q  <= neg_in;
            cnt_q  <= '0;
            opnd_q <= cls_in.is_div ? mag_b_in : mag_a_in;
            acc_q  <= {{XLEN{1'b0}}, (cls_in.is_div ? mag_a_in : mag_b_in)};
            if (direct_done) result_q <= direct_res;
        end else if (state_q == S_CALC) begin
            acc_q <= calc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) result_q <= fix_up(op_q, neg_q, calc_nxt);
        end
    end

    assign o_result = result_q;
    assign o_tag    = tag_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed self-checking bench for rv_muldiv_unit (XLEN=32, TAG_W=5).
`timescale 1ns/1ps
module tb_rv_muldiv_unit;
    import rv_mdu_pkg::*;

`ifdef RV_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [2:0]  i_op;
    logic [31:0] i_a, i_b;
    logic [4:0]  i_tag;
    logic        i_flush;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;

    rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_tag       (i_tag),
        .i_flush     (i_flush),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_tag       (o_tag),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 0) and measure the cycle o_out_valid first rises
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        check({name, "_in_ready"}, o_in_ready, 1);
        i_in_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_tag = tag;
        tick();
        i_in_valid = 1'b0;
        lat = 1;
        while (!o_out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_res"}, o_result, exp);
        check({name, "_tag"}, o_tag, tag);
        if (i_out_ready) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        int          bad;
        int          seen;

        i_reset = 1'b1; i_in_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        i_tag = '0; i_flush = 1'b0; i_out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", o_out_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_tag", o_tag, 0);
        check("rst_busy", o_busy, 0);
        check("rst_in_ready", o_in_ready, 1);
        i_reset = 1'b0;
        tick();

        run_op("mul",    MDU_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
        run_op("mul2",   MDU_MUL,    32'h1234_5678, 32'h0000_0010, 5'd1, 32'h2345_6780, MUL_LAT);
        run_op("mulh",   MDU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, MUL_LAT);
        run_op("mulhu",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div",    MDU_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem",    MDU_REM,    32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu",   MDU_DIVU,   32'd100,       32'd7,         5'd8, 32'd14,        DIV_LAT);
        run_op("remu",   MDU_REMU,   32'd100,       32'd7,         5'd9, 32'd2,         DIV_LAT);

        run_op("div0",   MDU_DIV,    32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        run_op("remu0",  MDU_REMU,   32'd5,         32'd0,         5'd11, 32'd5,         1);
        run_op("divu0",  MDU_DIVU,   32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 1);
        run_op("rem0",   MDU_REM,    32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFF9, 1);
        run_op("div_ovf", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        run_op("rem_ovf", MDU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         1);

        // Backpressure: result must hold while the consumer stalls
        i_out_ready = 1'b0;
        run_op("bp", MDU_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, DIV_LAT);
        held_res = o_result;
        held_tag = o_tag;
        bad = 0;
        repeat (10) begin
            tick();
            if (o_result !== 32'd14 || o_tag !== 5'd20 || o_in_ready !== 1'b0 ||
                o_busy !== 1'b1 || o_out_valid !== 1'b1) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_held_res", held_res, 32'd14);
        check("bp_held_tag", held_tag, 5'd20);
        i_out_ready = 1'b1;
        tick();
        check("bp_release_ready", o_in_ready, 1);
        check("bp_release_busy", o_busy, 0);
        run_op("bp_next", MDU_MUL, 32'd6, 32'd7, 5'd21, 32'd42, MUL_LAT);

        // Flush in cycle 10 of a DIV
        i_in_valid = 1'b1; i_op = MDU_DIV; i_a = 32'd1000; i_b = 32'd3; i_tag = 5'd22;
        tick();
        i_in_valid = 1'b0;
        repeat (9) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_in_ready", o_in_ready, 1);
        check("flush_busy", o_busy, 0);
        seen = 0;
        repeat (40) begin
            if (o_out_valid) seen++;
            tick();
        end
        check("flush_no_valid", seen, 0);

        // Flush beats a simultaneous accept
        i_in_valid = 1'b1; i_flush = 1'b1; i_op = MDU_MUL;
        tick();
        i_in_valid = 1'b0; i_flush = 1'b0;
        check("flush_vs_accept", o_busy, 0);

        run_op("recover", MDU_REMU, 32'd100, 32'd7, 5'd3, 32'd2, DIV_LAT);

        // Reset mid-CALC clears outputs asynchronously
        i_in_valid = 1'b1; i_op = MDU_MULHU; i_a = 32'hDEAD_BEEF; i_b = 32'h1234_5678; i_tag = 5'd17;
        tick();
        i_in_valid = 1'b0;
        repeat (5) tick();
        i_reset = 1'b1;
        #1;
        check("arst_valid", o_out_valid, 0);
        check("arst_result", o_result, 0);
        check("arst_tag", o_tag, 0);
        check("arst_busy", o_busy, 0);
        tick();
        i_reset = 1'b0;
        tick();
        run_op("post_rst", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
